alu_result_checker: RTL

- Synthesizable in-fabric scoreboard on the monitor side of the ALU stimulus interface.
- Each clock it samples the ALU operands and controls, computes the expected signed result with a golden model, and delays it by LATENCY cycles.
- It compares the delayed value against the ALU output c, then counts passes and fails and captures the first mismatch.
- Used in emulation/FPGA bring-up alongside the UVM monitor.

---
 rtl/alu_result_checker.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - in-fabric scoreboard comparing ALU result c against a delayed golden model
module alu_result_checker #(
    parameter int LATENCY      = 1,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ALU_en,
    input  logic                    a_en,
    input  logic                    b_en,
    input  logic [2:0]              a_op,
    input  logic [1:0]              b_op,
    input  logic signed [4:0]       A,
    input  logic signed [4:0]       B,
    input  logic signed [5:0]       c,
    input  logic                    clr,
    output logic [CNT_W-1:0]        pass_cnt,
    output logic [CNT_W-1:0]        fail_cnt,
    output logic                    mismatch,
    output logic                    err,
    output logic [5:0]              first_exp,
    output logic [5:0]              first_act,
    output logic                    halted
);

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_CHECK  = 2'd1,
        S_HALT   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_warm;
    logic [6:0]         r_pipe [LATENCY];
    logic [5:0]         r_hold;
    logic [CNT_W-1:0]   r_pass;
    logic [CNT_W-1:0]   r_fail;
    logic               r_mismatch;
    logic               r_err;
    logic [5:0]         r_first_exp;
    logic [5:0]         r_first_act;

    logic signed [5:0]  w_a6;
    logic signed [5:0]  w_b6;
    logic signed [5:0]  w_calc;
    logic               w_valid;
    logic [5:0]         w_exp;
    logic [6:0]         w_head;
    logic               w_cmp;
    logic               w_match;

    // Bitwise ops on sign-extended operands equal the sign-extended 5-bit result.
    assign w_a6 = {A[4], A};
    assign w_b6 = {B[4], B};

    always_comb begin
        w_calc  = '0;
        w_valid = 1'b0;
        if (ALU_en) begin
            case ({a_en, b_en})
                2'b10: begin
                    w_valid = (a_op != 3'd7);
                    case (a_op)
                        3'd0:    w_calc = w_a6 + w_b6;
                        3'd1:    w_calc = w_a6 - w_b6;
                        3'd2:    w_calc = w_a6 ^ w_b6;
                        3'd3:    w_calc = w_a6 & w_b6;
                        3'd4:    w_calc = w_a6 | w_b6;
                        3'd5:    w_calc = ~(w_a6 ^ w_b6);
                        3'd6:    w_calc = ~(w_a6 & w_b6);
                        default: w_calc = '0;
                    endcase
                end
                2'b01: begin
                    w_valid = (b_op != 2'd3);
                    case (b_op)
                        2'd0:    w_calc = ~(w_a6 & w_b6);
                        2'd1:    w_calc = w_a6 + w_b6;
                        2'd2:    w_calc = w_a6 + w_b6;
                        default: w_calc = '0;
                    endcase
                end
                2'b11: begin
                    w_valid = 1'b1;
                    case (b_op)
                        2'd0:    w_calc = w_a6 ^ w_b6;
                        2'd1:    w_calc = ~(w_a6 ^ w_b6);
                        2'd2:    w_calc = w_a6 - 6'sd1;
                        default: w_calc = w_b6 + 6'sd2;
                    endcase
                end
                default: w_valid = 1'b0;
            endcase
        end
        w_exp = w_valid ? w_calc : r_hold;
    end

    // Entry layout {chk, exp}; unchecked entries still travel so the delay stays fixed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
            r_hold <= '0;
        end else begin
            r_pipe[0] <= {w_valid, w_exp};
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if (w_valid) begin
                r_hold <= w_calc;
            end
        end
    end

    assign w_head  = r_pipe[LATENCY-1];
    assign w_cmp   = (r_state == S_CHECK) && !clr && w_head[6];
    assign w_match = (w_head[5:0] == $unsigned(c));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WARMUP: if (r_warm == 3'(LATENCY - 1)) w_state_nxt = S_CHECK;
            S_CHECK:  if (w_cmp && !w_match && (STOP_ON_FAIL != 0)) w_state_nxt = S_HALT;
            S_HALT:   if (clr) w_state_nxt = S_CHECK;
            default:  w_state_nxt = S_WARMUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_WARMUP;
            r_warm      <= '0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_mismatch  <= 1'b0;
            r_err       <= 1'b0;
            r_first_exp <= '0;
            r_first_act <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mismatch <= 1'b0;
            if (r_state == S_WARMUP) begin
                r_warm <= r_warm + 3'd1;
            end
            if (clr) begin
                r_pass      <= '0;
                r_fail      <= '0;
                r_err       <= 1'b0;
                r_first_exp <= '0;
                r_first_act <= '0;
            end else if (w_cmp) begin
                if (w_match) begin
                    if (r_pass != '1) r_pass <= r_pass + 1'b1;
                end else begin
                    if (r_fail != '1) r_fail <= r_fail + 1'b1;
                    r_mismatch <= 1'b1;
                    if (!r_err) begin
                        r_err       <= 1'b1;
                        r_first_exp <= w_head[5:0];
                        r_first_act <= $unsigned(c);
                    end
                end
            end
        end
    end

    assign pass_cnt  = r_pass;
    assign fail_cnt  = r_fail;
    assign mismatch  = r_mismatch;
    assign err       = r_err;
    assign first_exp = r_first_exp;
    assign first_act = r_first_act;
    assign halted    = (r_state == S_HALT);

endmodule
